// File: rtl/bcd_sevenseg_scan.sv
// Captures BCD operands and decimal-adder result, then scans them onto a
// 4-digit common-anode display. Optional leading-zero blanking: BCD_SCAN_LZB_EN.
module bcd_sevenseg_scan #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Load,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] Sum,
    input  logic       Cout,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam logic [19:0] DIV_MAX = 20'(REFRESH_DIV - 1);

    logic [19:0] div_q, div_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  ra_q, ra_d, rb_q, rb_d, rs_q, rs_d;
    logic        rc_q, rc_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  digit;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0000110;
        endcase
    endfunction

    always_comb begin
        div_d = div_q + 20'd1;
        idx_d = idx_q;
        if (div_q == DIV_MAX) begin
            div_d = '0;
            idx_d = idx_q + 2'd1;
        end

        ra_d = Load ? a    : ra_q;
        rb_d = Load ? b    : rb_q;
        rs_d = Load ? Sum  : rs_q;
        rc_d = Load ? Cout : rc_q;

        // Outputs are built from the current idx and capture registers, so
        // an and seg always change together on the next edge.
        an_d  = 4'b1110;
        digit = rs_q;
        case (idx_q)
            2'd0: begin an_d = 4'b1110; digit = rs_q;         end
            2'd1: begin an_d = 4'b1101; digit = {3'b000, rc_q}; end
            2'd2: begin an_d = 4'b1011; digit = rb_q;         end
            default: begin an_d = 4'b0111; digit = ra_q;      end
        endcase
        seg_d = decode(digit);
`ifdef BCD_SCAN_LZB_EN
        if (idx_q == 2'd1 && !rc_q) begin
            seg_d = 7'b1111111;
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            div_q <= '0;
            idx_q <= '0;
            ra_q  <= '0;
            rb_q  <= '0;
            rs_q  <= '0;
            rc_q  <= 1'b0;
            an_q  <= 4'b1111;
            seg_q <= 7'b1111111;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            ra_q  <= ra_d;
            rb_q  <= rb_d;
            rs_q  <= rs_d;
            rc_q  <= rc_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Self-checking bench for bcd_sevenseg_scan with REFRESH_DIV=4, compared
// against a cycle-count based display model.
module tb_bcd_sevenseg_scan;

    localparam int R = 4;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Load = 1'b0;
    logic [3:0] a = '0, b = '0, Sum = '0;
    logic       Cout = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;

    int errors = 0;
    int checks = 0;

    // Reference model state: edges since reset release, captured values.
    int k = 0;
    int m_ra = 0, m_rb = 0, m_rs = 0, m_rc = 0;
    logic [6:0] exp_seg = 7'b1111111;
    logic [3:0] exp_an  = 4'b1111;

    bcd_sevenseg_scan #(.REFRESH_DIV(R)) dut (
        .Clk(Clk), .Rst(Rst), .Load(Load), .a(a), .b(b),
        .Sum(Sum), .Cout(Cout), .seg(seg), .an(an)
    );

    always #5 Clk = ~Clk;

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: glyph = 7'b1000000;
            1: glyph = 7'b1111001;
            2: glyph = 7'b0100100;
            3: glyph = 7'b0110000;
            4: glyph = 7'b0011001;
            5: glyph = 7'b0010010;
            6: glyph = 7'b0000010;
            7: glyph = 7'b1111000;
            8: glyph = 7'b0000000;
            9: glyph = 7'b0010000;
            default: glyph = 7'b0000110;
        endcase
    endfunction

    // One clock: apply inputs, advance the model, sample 1 time unit later.
    task automatic cycle(input logic rst, input logic ld, input logic [3:0] ia,
                         input logic [3:0] ib, input logic [3:0] is, input logic ic);
        int slot;
        int val;
        Rst = rst; Load = ld; a = ia; b = ib; Sum = is; Cout = ic;
        @(posedge Clk);
        if (rst) begin
            k = 0; m_ra = 0; m_rb = 0; m_rs = 0; m_rc = 0;
            exp_an = 4'b1111; exp_seg = 7'b1111111;
        end else begin
            slot = (k / R) % 4;
            case (slot)
                0: begin exp_an = 4'b1110; val = m_rs; end
                1: begin exp_an = 4'b1101; val = m_rc; end
                2: begin exp_an = 4'b1011; val = m_rb; end
                default: begin exp_an = 4'b0111; val = m_ra; end
            endcase
            exp_seg = glyph(val);
`ifdef BCD_SCAN_LZB_EN
            if (slot == 1 && m_rc == 0) exp_seg = 7'b1111111;
`endif
            if (ld) begin
                m_ra = int'(ia); m_rb = int'(ib); m_rs = int'(is); m_rc = int'(ic);
            end
            k++;
        end
        #1;
    endtask

    task automatic idle(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
            checks++;
            if (an !== exp_an || seg !== exp_seg) begin
                errors++;
                $display("FAIL %s cyc%0d: an=%b seg=%b expected an=%b seg=%b",
                         name, i, an, seg, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
            checks++;
            if (an !== 4'b1111 || seg !== 7'b1111111) begin
                errors++;
                $display("FAIL reset: an=%b seg=%b expected an=1111 seg=1111111", an, seg);
            end
        end
    endtask

    task automatic test_scan();
        cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        checks++;
        if (an !== 4'b1110 || seg !== 7'b1000000) begin
            errors++;
            $display("FAIL first_edge: an=%b seg=%b expected an=1110 seg=1000000", an, seg);
        end
        for (int i = 0; i < 19; i++) begin
            cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
            checks++;
            if (an !== exp_an || seg !== exp_seg || $countones(an) != 3) begin
                errors++;
                $display("FAIL scan cyc%0d: an=%b seg=%b expected an=%b seg=%b",
                         i, an, seg, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_load_digits();
        cycle(1'b0, 1'b1, 4'd7, 4'd5, 4'd2, 1'b1);
        checks++;
        if (an !== exp_an || seg !== exp_seg) begin
            errors++;
            $display("FAIL load12_edge: an=%b seg=%b expected an=%b seg=%b", an, seg, exp_an, exp_seg);
        end
        idle(16, "load12");
    endtask

    task automatic test_tens_zero();
        cycle(1'b0, 1'b1, 4'd3, 4'd4, 4'd7, 1'b0);
        idle(16, "load07");
    endtask

    task automatic test_invalid();
        cycle(1'b0, 1'b1, 4'd12, 4'd15, 4'd10, 1'b1);
        idle(16, "invalid");
    endtask

    task automatic test_rst_load();
        cycle(1'b1, 1'b1, 4'd9, 4'd9, 4'd9, 1'b1);
        checks++;
        if (an !== 4'b1111 || seg !== 7'b1111111) begin
            errors++;
            $display("FAIL rst_load: an=%b seg=%b expected an=1111 seg=1111111", an, seg);
        end
        idle(16, "rst_load");
    endtask

    task automatic test_rst_midframe();
        // Restart the frame, then stop at idx=2, div=2.
        cycle(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        cycle(1'b0, 1'b1, 4'd6, 4'd8, 4'd1, 1'b1);
        idle(2 * R + 1, "pre_mid");
        cycle(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        checks++;
        if (an !== 4'b1110 || seg !== 7'b1000000) begin
            errors++;
            $display("FAIL mid_rst_first: an=%b seg=%b expected an=1110 seg=1000000", an, seg);
        end
        idle(R + 3, "mid_rst_dwell");
    endtask

    task automatic test_random();
        logic rst, ld;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            ld  = ($urandom_range(0, 9) == 0);
            cycle(rst, ld, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            checks++;
            if (an !== exp_an || seg !== exp_seg) begin
                errors++;
                $display("FAIL random cyc%0d: an=%b seg=%b expected an=%b seg=%b",
                         i, an, seg, exp_an, exp_seg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_digits();
        test_tens_zero();
        test_invalid();
        test_rst_load();
        test_rst_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_sevenseg_scan.md
# bcd_sevenseg_scan

Display stage directly downstream of the decimal (BCD) adder. Captures the two BCD operand digits and the decimal adder's Sum/Cout result on a load strobe, and time-multiplexes all four onto a 4-digit common-anode seven-segment display through the `seg`/`an` outputs. The display order is operand A, operand B, result tens, result ones.

## Interface
Parameters:
- `REFRESH_DIV`, default 100000: Clk cycles each digit stays lit. Legal range 1 to 2^20−1.

Ports:
- `Clk` input 1: single clock, rising edge.
- `Rst` input 1: reset, synchronous and active-high.
- `Load` input 1: capture strobe. The inputs are sampled on any rising edge where `Load`=1.
- `a` input 4: operand A BCD digit.
- `b` input 4: operand B BCD digit.
- `Sum` input 4: result ones digit from the decimal adder.
- `Cout` input 1: result tens digit (0 or 1) from the decimal adder.
- `seg` output 7: segments {g,f,e,d,c,b,a}, active-low, registered.
- `an` output 4: digit anodes, active-low, registered. `an[0]` is the rightmost digit.

## Operation
Capture registers `ra`, `rb`, `rs` (4 bits each) and `rc` (1 bit):
- On `Load`=1, they are loaded from `a`, `b`, `Sum`, `Cout`.
- Otherwise they hold their value.
- Reset value is 0 for all.

Scan counter `div`, 20 bits:
- Counts 0 to REFRESH_DIV−1, then wraps to 0.
- On the wrap cycle, digit index `idx` (2 bits) advances 0→1→2→3→0.

Digit select by `idx`:
- 0: `an`=1110, shows `rs`.
- 1: `an`=1101, shows tens digit {3'b000,`rc`}.
- 2: `an`=1011, shows `rb`.
- 3: `an`=0111, shows `ra`.

Decode (active-low):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Any value 10 to 15 shows "E", 0000110.
- Blank is 1111111.

Exactly one anode is low in every non-reset cycle. No ghosting: `an` and `seg` update on the same edge.

## Timing
- Reset: while `Rst`=1 at an edge, the following values are forced:
  - `an`=1111 and `seg`=1111111.
  - `div`=0 and `idx`=0.
  - Capture registers cleared.
- First edge after `Rst` falls: `an`=1110, `seg`=1000000 (ones digit of 0).
- Output register latency: `an`/`seg` reflect `idx` and capture-register state from the previous cycle, so one cycle of latency.
- A `Load` at edge N is visible on `seg` at edge N+1 if that digit is currently selected. Otherwise it appears when the digit's slot comes round.
- Each digit is lit for exactly REFRESH_DIV consecutive cycles. A full frame is 4×REFRESH_DIV cycles.
- REFRESH_DIV=1: `idx` advances every cycle.
- `Load` and scanning are independent. `Load` never resets `div` or `idx`.
- `Rst` and `Load` asserted together: `Rst` wins and nothing is captured.
- `Rst` mid-frame: the scan restarts at `idx`=0 with a full REFRESH_DIV dwell.

## Configuration
Macro: `BCD_SCAN_LZB_EN`
- Defined (leading-zero blanking): when `rc`=0 and `idx`=1, `seg`=1111111 and `an` still = 1101, so anode timing is unchanged. When `rc`=1 the tens digit shows "1" normally.
- Not defined: the tens digit always shows 0 or 1.

## Test plan
All scenarios use REFRESH_DIV=4.
1. Reset, then release: first edge gives `an`=1110, `seg`=1000000. `an` then steps 1101, 1011, 0111 every 4 cycles and returns to 1110 at cycle 16.
2. Load a=7, b=5, Sum=2, Cout=1 (12): over one frame, `seg` sequence is ones 0100100, tens 1111001, b 0010010, a 1111000.
3. Load a=3, b=4, Sum=7, Cout=0:
   - Without the macro, the tens slot shows 1000000.
   - With `BCD_SCAN_LZB_EN`, the tens slot shows 1111111 while `an`=1101.
4. Load a=12 (invalid BCD): the `an`=0111 slot shows 0000110 ("E").
5. Assert `Load` and `Rst` together with a=9, then release `Rst`: all captured values are 0 and the `an`=0111 slot shows 1000000.
6. Assert `Rst` for one cycle at `idx`=2, `div`=2: the next edge gives `an`=1110, and the ones digit dwells a full 4 cycles.
